// File: rtl/arb_requester_if.sv
// Job, arbiter and beat-stream signals for one requester agent.
// The design side uses the slave modport; the driving side uses master.
interface arb_requester_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  logic              job_valid_i;
  logic              job_ready_o;
  logic [DATA_W-1:0] job_data_i;
  logic [LEN_W-1:0]  job_len_i;
  logic              req_o;
  logic              gnt_i;
  logic              out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic              out_last_o;
  logic              busy_o;
  logic              starve_o;

  modport slave (
    input  job_valid_i, job_data_i, job_len_i, gnt_i,
    output job_ready_o, req_o, out_valid_o, out_data_o, out_last_o, busy_o, starve_o
  );

  modport master (
    output job_valid_i, job_data_i, job_len_i, gnt_i,
    input  job_ready_o, req_o, out_valid_o, out_data_o, out_last_o, busy_o, starve_o
  );
endinterface

// File: rtl/arb_requester.sv
// Requester agent for one arbiter port: queues jobs, requests the port,
// streams each job's beats while granted and leaves a one-cycle req gap
// between jobs so the arbiter can rotate. Flags long waits for grant.
module arb_requester #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 4,
  parameter int TIMEOUT    = 15
) (
  input logic          clk,
  input logic          rst,
  arb_requester_if.slave bus
);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

  state_t            r_state;
  state_t            w_next;

  logic [DATA_W-1:0] r_memData [FIFO_DEPTH];
  logic [LEN_W-1:0]  r_memLen  [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic [DATA_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [WAIT_W-1:0] r_wait;
  logic              r_starve;
  logic              r_valid;
  logic              r_last;
  logic [DATA_W-1:0] r_data;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_emit;
  logic              w_emitLast;
  logic [DATA_W-1:0] w_emitData;
  logic [DATA_W-1:0] w_headData;
  logic [LEN_W-1:0]  w_headLen;

  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = bus.job_valid_i && !w_full;
  assign w_pop      = (r_state == REQ) && bus.gnt_i;
  assign w_headData = r_memData[r_rptr];
  assign w_headLen  = r_memLen[r_rptr];

  // Next state and the beat to register this cycle; a grant in REQ emits beat 0 straight from the FIFO head.
  always_comb begin
    w_next     = r_state;
    w_emit     = 1'b0;
    w_emitData = r_data;
    w_emitLast = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) w_next = REQ;
      end
      REQ: begin
        if (bus.gnt_i) begin
          w_next     = XFER;
          w_emit     = 1'b1;
          w_emitData = w_headData;
          w_emitLast = (w_headLen == '0);
        end
      end
      XFER: begin
        if (r_valid && r_last) begin
          w_next = GAP;
        end else if (bus.gnt_i) begin
          w_emit     = 1'b1;
          w_emitData = r_base + DATA_W'(r_cnt);
          w_emitLast = (r_cnt == r_len);
        end
      end
      GAP: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Job storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memData[r_wptr] <= bus.job_data_i;
      r_memLen[r_wptr]  <= bus.job_len_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Working job registers, beat output registers and grant-wait tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_wait   <= '0;
      r_starve <= 1'b0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_data   <= '0;
    end else begin
      r_valid <= w_emit;
      r_last  <= w_emitLast;
      if (w_emit) r_data <= w_emitData;
      if (w_pop) begin
        r_base <= w_headData;
        r_len  <= w_headLen;
        r_cnt  <= LEN_W'(1);
      end else if (w_emit) begin
        r_cnt <= r_cnt + LEN_W'(1);
      end
      if (r_state == REQ) begin
        if (bus.gnt_i) begin
          r_wait   <= '0;
          r_starve <= 1'b0;
        end else begin
          if (r_wait != WAIT_W'(TIMEOUT)) r_wait <= r_wait + WAIT_W'(1);
          if (r_wait >= WAIT_W'(TIMEOUT - 1)) r_starve <= 1'b1;
        end
      end
    end
  end

  assign bus.job_ready_o = !w_full;
  assign bus.req_o       = (r_state == REQ) || (r_state == XFER);
  assign bus.out_valid_o = r_valid;
  assign bus.out_data_o  = r_data;
  assign bus.out_last_o  = r_last;
  assign bus.busy_o      = (r_state != IDLE) || !w_empty;
  assign bus.starve_o    = r_starve;
endmodule

// File: tb/tb_arb_requester.sv
// Scoreboard bench for arb_requester: accepted jobs expand into expected
// beats (base + i, last on i == len); a monitor pops them as beats appear.
module tb_arb_requester;
  localparam int DATA_W  = 8;
  localparam int LEN_W   = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              first;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  beat_t expQ[$];
  beat_t monBeat;
  beat_t recBeat;
  int    checks    = 0;
  int    failures  = 0;
  int    accepted  = 0;
  int    started   = 0;
  int    beatCount = 0;
  int    occ;

  arb_requester_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  arb_requester #(
    .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [DATA_W-1:0] data,
                               input logic [LEN_W-1:0] len, input logic gnt);
    bus.job_valid_i = valid;
    bus.job_data_i  = data;
    bus.job_len_i   = len;
    bus.gnt_i       = gnt;
  endtask

  task automatic stepToDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic stepToSample();
    @(negedge clk);
    #1;
  endtask

  task automatic waitBeats(input int target, input string name);
    int n = 0;
    while (beatCount < target && n < 200) begin
      stepToSample();
      n++;
    end
    checkOutput(name, beatCount >= target, 1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    applyStimulus(1'b0, '0, '0, 1'b1);
    stepToSample();
    while ((expQ.size() != 0 || bus.busy_o) && n < 600) begin
      stepToSample();
      n++;
    end
    checkOutput({name, "_queue_empty"}, expQ.size(), 0);
    checkOutput({name, "_busy_low"}, bus.busy_o, 0);
  endtask

  // Reference model: each accepted job becomes len+1 expected beats.
  always @(posedge clk) begin
    if (rst) begin
      expQ.delete();
      accepted = 0;
      started  = 0;
    end else if (bus.job_valid_i && bus.job_ready_o) begin
      for (int i = 0; i <= int'(bus.job_len_i); i++) begin
        recBeat.data  = bus.job_data_i + DATA_W'(i);
        recBeat.last  = (i == int'(bus.job_len_i));
        recBeat.first = (i == 0);
        expQ.push_back(recBeat);
      end
      accepted++;
    end
  end

  // Monitor: compares presented beats and the FIFO-occupancy-derived ready/busy.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid_o) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL beat_unexpected: got beat %0h, required no beat", bus.out_data_o);
        end else begin
          monBeat = expQ.pop_front();
          if (monBeat.first) started++;
          checkOutput("beat_data", bus.out_data_o, monBeat.data);
          checkOutput("beat_last", bus.out_last_o, monBeat.last);
          beatCount++;
        end
      end else begin
        checkOutput("last_without_valid", bus.out_last_o, 0);
      end
      occ = accepted - started;
      checkOutput("job_ready", bus.job_ready_o, occ < DEPTH);
      if (occ > 0) checkOutput("busy_with_jobs", bus.busy_o, 1);
    end
  end

  // Hard stop in case something never finishes.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized run.
  initial begin
    int accBase;
    int target;
    int n;

    applyStimulus(1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    stepToSample();
    checkOutput("reset_req", bus.req_o, 0);
    checkOutput("reset_valid", bus.out_valid_o, 0);
    checkOutput("reset_last", bus.out_last_o, 0);
    checkOutput("reset_starve", bus.starve_o, 0);
    checkOutput("reset_busy", bus.busy_o, 0);
    checkOutput("reset_data", bus.out_data_o, 0);
    checkOutput("reset_ready", bus.job_ready_o, 1);

    // Single job 0x10 len 2 with grant always available.
    stepToDrive();
    applyStimulus(1'b1, 8'h10, 4'd2, 1'b1);
    stepToDrive();
    applyStimulus(1'b0, '0, '0, 1'b1);
    stepToSample();
    checkOutput("single_req_not_yet", bus.req_o, 0);
    stepToSample();
    checkOutput("single_req_rise", bus.req_o, 1);
    for (int i = 0; i < 3; i++) begin
      stepToSample();
      checkOutput("single_beat_valid", bus.out_valid_o, 1);
    end
    stepToSample();
    checkOutput("single_gap_req", bus.req_o, 0);
    checkOutput("single_gap_valid", bus.out_valid_o, 0);
    stepToSample();
    checkOutput("single_busy_fall", bus.busy_o, 0);

    // Fill the queue with grant withheld; watch starvation and hold-off.
    stepToDrive();
    accBase = accepted;
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b1, DATA_W'($urandom), LEN_W'($urandom_range(0, 3)), 1'b0);
      stepToDrive();
    end
    applyStimulus(1'b1, DATA_W'($urandom), LEN_W'($urandom_range(0, 3)), 1'b0);
    for (int k = 4; k <= 20; k++) begin
      stepToSample();
      checkOutput("fill_ready_low", bus.job_ready_o, 0);
      checkOutput("fill_req_high", bus.req_o, 1);
      checkOutput("starve_level", bus.starve_o, k >= 17);
    end
    bus.gnt_i = 1'b1;
    stepToSample();
    checkOutput("starve_cleared", bus.starve_o, 0);
    checkOutput("fill_first_beat", bus.out_valid_o, 1);
    n = 0;
    while (accepted < accBase + 5 && n < 50) begin
      stepToDrive();
      n++;
    end
    checkOutput("fill_fifth_accepted", accepted - accBase, 5);
    drain("fill");

    // Grant dropped for two cycles mid-job, data wrapping past 0xFF.
    stepToDrive();
    applyStimulus(1'b1, 8'hFE, 4'd3, 1'b1);
    stepToDrive();
    applyStimulus(1'b0, '0, '0, 1'b1);
    target = beatCount + 2;
    waitBeats(target, "stall_reach_beat1");
    bus.gnt_i = 1'b0;
    stepToSample();
    checkOutput("stall_valid_low1", bus.out_valid_o, 0);
    stepToSample();
    checkOutput("stall_valid_low2", bus.out_valid_o, 0);
    bus.gnt_i = 1'b1;
    stepToSample();
    checkOutput("stall_resume", bus.out_valid_o, 1);
    drain("stall");

    // Reset during beat 2 of a len 5 job with two more queued.
    stepToDrive();
    applyStimulus(1'b1, 8'h40, 4'd5, 1'b0);
    stepToDrive();
    applyStimulus(1'b1, DATA_W'($urandom), LEN_W'($urandom_range(0, 3)), 1'b0);
    stepToDrive();
    applyStimulus(1'b1, DATA_W'($urandom), LEN_W'($urandom_range(0, 3)), 1'b0);
    stepToDrive();
    applyStimulus(1'b0, '0, '0, 1'b1);
    target = beatCount + 3;
    waitBeats(target, "reset_reach_beat2");
    rst = 1'b1;
    stepToDrive();
    rst = 1'b0;
    stepToSample();
    checkOutput("midreset_req", bus.req_o, 0);
    checkOutput("midreset_valid", bus.out_valid_o, 0);
    checkOutput("midreset_ready", bus.job_ready_o, 1);
    checkOutput("midreset_busy", bus.busy_o, 0);
    repeat (8) stepToSample();
    checkOutput("midreset_still_idle", bus.busy_o, 0);

    // Push and pop on the same edge at occupancy three.
    stepToDrive();
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b1, DATA_W'($urandom), LEN_W'($urandom_range(0, 3)), 1'b0);
      stepToDrive();
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    stepToSample();
    checkOutput("occ3_ready", bus.job_ready_o, 1);
    applyStimulus(1'b1, DATA_W'($urandom), LEN_W'($urandom_range(0, 3)), 1'b1);
    stepToDrive();
    applyStimulus(1'b0, '0, '0, 1'b1);
    stepToSample();
    checkOutput("simul_ready", bus.job_ready_o, 1);
    checkOutput("simul_first_beat", bus.out_valid_o, 1);
    drain("simul");

    // Randomized jobs and grant pattern.
    for (int c = 0; c < 300; c++) begin
      stepToDrive();
      applyStimulus(1'($urandom % 2), DATA_W'($urandom), LEN_W'($urandom), ($urandom % 4) != 0);
    end
    stepToDrive();
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
Requester-side agent for the 4-port request/grant arbiter. It sits on one arbiter port and owns that port's req/gnt pair.
- Queues incoming jobs in a small FIFO.
- Raises req for the head job and waits for gnt.
- Streams the job's data beats while granted.
- Drops req for a mandatory one-cycle gap so the arbiter can rotate to other ports.
- Flags starvation when the wait for gnt exceeds a limit.

Parameters:
DATA_W, 8, width of job data / output beat
FIFO_DEPTH, 4, job queue entries (power of 2, >=2)
LEN_W, 4, job length field width; beats per job = job_len_i + 1
TIMEOUT, 15, REQ-state wait cycles before starve_o asserts (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
job_valid_i  input  1  job offered
job_ready_o  output  1  job accepted when valid & ready
job_data_i  input  DATA_W  start value of job beats
job_len_i  input  LEN_W  beat count minus one
req_o  output  1  request to arbiter port
gnt_i  input  1  grant from arbiter port
out_valid_o  output  1  beat valid
out_data_o  output  DATA_W  beat data
out_last_o  output  1  final beat of job
busy_o  output  1  FSM not IDLE or FIFO non-empty
starve_o  output  1  wait for grant reached TIMEOUT

Behaviour:
- Reset (rst high at clock edge):
  - FSM goes to IDLE; FIFO empty; all counters 0.
  - req_o, out_valid_o, out_last_o, starve_o, busy_o = 0; out_data_o = 0; job_ready_o = 1 on the cycle after reset.
  - Reset mid-transfer abandons the job and flushes the FIFO; no further beats are emitted.
- FIFO:
  - job_ready_o = !full (registered occupancy). A push takes {data, len}.
  - Pop occurs on the REQ->XFER transition.
  - Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
  - When full, job_ready_o = 0 even if a pop occurs that cycle. Offered jobs are held off, never dropped.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, REQ, XFER, GAP.
  - IDLE: FIFO non-empty -> REQ next cycle. A job pushed at edge t has req_o high from t+1 to t+2 (at most one cycle in IDLE).
  - REQ: req_o = 1; wait counter increments each cycle gnt_i = 0, saturating at TIMEOUT. gnt_i = 1 -> XFER; pop the head job into working registers (base, len); beat counter = 0; wait counter cleared.
  - XFER: req_o = 1.
    - A beat is emitted in a cycle where gnt_i = 1: out_valid_o = 1, out_data_o = base + beat counter (mod 2^DATA_W), out_last_o = (beat counter == len).
    - If gnt_i = 0 in XFER: out_valid_o = 0, and the counter and data hold (stall; resumes when gnt_i returns).
    - After the last beat -> GAP.
  - GAP: req_o = 0 for exactly one cycle, then IDLE. No back-to-back req on the same port.
- Output timing: outputs are registered. The first beat appears in the first XFER cycle, one cycle after gnt_i is sampled high in REQ.
- starve_o: set when the wait counter reaches TIMEOUT in REQ; stays high until gnt_i is sampled in REQ, then cleared on the next edge.
- busy_o: high whenever state != IDLE or the FIFO is non-empty.

Test Plan:
- Single job data=0x10 len=2, gnt_i tied high when req_o: req_o rises 1 cycle after push; beats 0x10, 0x11, 0x12 on 3 consecutive cycles, out_last_o on 0x12; req_o low 1 cycle; busy_o falls.
- Fill 4 jobs with gnt_i low: job_ready_o = 0 after the 4th push; 5th job is held until the first pop; jobs emerge in FIFO order with a 1-cycle req_o gap between jobs.
- Grant withheld 15 cycles with TIMEOUT=15: starve_o rises after cycle 15 of REQ and clears 1 cycle after gnt_i is sampled high.
- gnt_i dropped for 2 cycles mid-XFER of a len=3 job from 0xFE: out_valid_o low for those 2 cycles; beat sequence 0xFE, 0xFF, 0x00, 0x01 with no skip or repeat; wrap is correct.
- rst asserted during beat 2 of a len=5 job with 2 queued: next cycle req_o = 0, out_valid_o = 0, FIFO empty, job_ready_o = 1, no further beats.
- Simultaneous push and pop at occupancy 3: occupancy stays 3; job_ready_o stays 1.
